dmem_byte_arbiter: RTL and testbench

- Shares the byte-wide data memory between two requesters: port 0 is the CPU load/store unit and port 1 is the DMA/debug loader.
- Each requester issues word, halfword or byte accesses using the existing type encoding.
- The block arbitrates between the ports, then sequences each access as consecutive single-byte memory cycles in little-endian order, assembling read data.
- Sits between the core/DMA and the byte memory array, replacing direct multi-byte indexing.

---
 rtl/dmem_byte_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_dmem_byte_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_byte_arbiter.sv
// Two-port arbiter in front of the byte-wide data memory.
// Word/halfword/byte accesses are split into little-endian byte cycles.
module dmem_byte_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter bit RR_ENABLE  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  rw0,
  input  logic                  rw1,
  input  logic [1:0]            type0,
  input  logic [1:0]            type1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [31:0]           wdata0,
  input  logic [31:0]           wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [31:0]           rdata0,
  output logic [31:0]           rdata1,
  output logic                  err,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [7:0]            m_wdata,
  output logic                  m_we,
  input  logic [7:0]            m_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_d;

  logic                  gnt_q;
  logic                  last_q;
  logic                  rw_q;
  logic                  err_q;
  logic [1:0]            cnt_q;
  logic [1:0]            end_q;
  logic [31:0]           wdata_q;
  logic [31:0]           asm_q;
  logic [31:0]           asm_nxt;
  logic [31:0]           rdata0_q;
  logic [31:0]           rdata1_q;
  logic [ADDR_WIDTH-1:0] base_q;

  logic                  any_req;
  logic                  sel1;
  logic                  s_rw;
  logic [1:0]            s_type;
  logic [1:0]            s_end;
  logic [ADDR_WIDTH-1:0] s_addr;
  logic [ADDR_WIDTH-1:0] s_base;
  logic [31:0]           s_wdata;
  logic                  last_byte;

  assign any_req = req0 | req1;

  // Round-robin hands a tie to the port that did not win last time.
  assign sel1 = RR_ENABLE ? (req1 & (~req0 | ~last_q))
                          : (req1 & ~req0);

  always_comb begin
    s_rw    = rw0;
    s_type  = type0;
    s_addr  = addr0;
    s_wdata = wdata0;
    if (sel1) begin
      s_rw    = rw1;
      s_type  = type1;
      s_addr  = addr1;
      s_wdata = wdata1;
    end
  end

  always_comb begin
    s_base = s_addr;
    s_end  = 2'd0;
    unique case (s_type)
      2'b00: begin
        s_base[1:0] = 2'b00;
        s_end       = 2'd3;
      end
      2'b01: begin
        s_base[0] = 1'b0;
        s_end     = 2'd1;
      end
      default: ;
    endcase
  end

  assign last_byte = (cnt_q == end_q);

  always_comb begin
    asm_nxt = asm_q;
    asm_nxt[{cnt_q, 3'b000} +: 8] = m_rdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    m_addr  = '0;
    m_wdata = '0;
    m_we    = 1'b0;
    ack0    = 1'b0;
    ack1    = 1'b0;
    err     = 1'b0;
    busy    = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req)
          state_d = (s_type == 2'b11) ? DONE : XFER;
      end
      XFER: begin
        busy    = 1'b1;
        m_addr  = base_q + ADDR_WIDTH'(cnt_q);
        m_wdata = wdata_q[{cnt_q, 3'b000} +: 8];
        m_we    = rw_q;
        if (last_byte) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        ack0    = ~gnt_q;
        ack1    = gnt_q;
        err     = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      rw_q     <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= 2'd0;
      end_q    <= 2'd0;
      wdata_q  <= '0;
      asm_q    <= '0;
      base_q   <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (any_req) begin
            gnt_q   <= sel1;
            last_q  <= sel1;
            rw_q    <= s_rw;
            err_q   <= (s_type == 2'b11);
            cnt_q   <= 2'd0;
            end_q   <= s_end;
            wdata_q <= s_wdata;
            base_q  <= s_base;
            asm_q   <= '0;
          end
        end
        (state == XFER): begin
          cnt_q <= cnt_q + 2'd1;
          if (!rw_q) asm_q <= asm_nxt;
          // Final byte lands in rdata on the edge that raises ack.
          if (!rw_q && last_byte) begin
            if (gnt_q) rdata1_q <= asm_nxt;
            else       rdata0_q <= asm_nxt;
          end
        end
        (state == DONE): begin
          err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_dmem_byte_arbiter.sv
// Directed bench for dmem_byte_arbiter: vector table plus
// reset-abort and contention sequences on RR and fixed-priority copies.
module tb_dmem_byte_arbiter;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic          rw0 = 1'b0, rw1 = 1'b0;
  logic [1:0]    type0 = 2'b0, type1 = 2'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [31:0]   wdata0 = '0, wdata1 = '0;

  logic          ack0, ack1, err, busy, m_we;
  logic [31:0]   rdata0, rdata1;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_wdata, m_rdata;

  logic          f_ack0, f_ack1, f_err, f_busy, f_m_we;
  logic [31:0]   f_rdata0, f_rdata1;
  logic [AW-1:0] f_m_addr;
  logic [7:0]    f_m_wdata, f_m_rdata;

  logic [7:0] mem  [256] = '{default: 8'h00};
  logic [7:0] memf [256] = '{default: 8'h00};

  always #5 clk = ~clk;

  assign m_rdata   = mem[m_addr[7:0]];
  assign f_m_rdata = memf[f_m_addr[7:0]];

  always @(posedge clk) if (m_we) mem[m_addr[7:0]] <= m_wdata;
  always @(posedge clk) if (f_m_we) memf[f_m_addr[7:0]] <= f_m_wdata;

  dmem_byte_arbiter #(.ADDR_WIDTH(AW), .RR_ENABLE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .type0(type0), .type1(type1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .err(err), .busy(busy), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_we(m_we), .m_rdata(m_rdata)
  );

  dmem_byte_arbiter #(.ADDR_WIDTH(AW), .RR_ENABLE(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .type0(type0), .type1(type1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(f_ack0), .ack1(f_ack1), .rdata0(f_rdata0), .rdata1(f_rdata1),
    .err(f_err), .busy(f_busy), .m_addr(f_m_addr), .m_wdata(f_m_wdata),
    .m_we(f_m_we), .m_rdata(f_m_rdata)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] rd0 = '0;
  logic [31:0] rd1 = '0;

  typedef struct {
    logic        port;
    logic        rw;
    logic [1:0]  typ;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    logic        err;
    logic [7:0]  base;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic access(input int idx, input vec_t v);
    int n, wes;
    logic [7:0] first;
    logic got;
    string tag;
    tag = $sformatf("v%0d", idx);
    if (v.port) begin
      req1 = 1'b1; rw1 = v.rw; type1 = v.typ;
      addr1 = v.addr; wdata1 = v.wdata;
    end else begin
      req0 = 1'b1; rw0 = v.rw; type0 = v.typ;
      addr0 = v.addr; wdata0 = v.wdata;
    end
    n = 0; wes = 0; first = 8'h00; got = 1'b0;
    while (!got && n < 20) begin
      tick;
      n++;
      if (n == 1) first = m_addr[7:0];
      if (m_we) wes++;
      if (ack0 | ack1) begin
        got = 1'b1;
        chk({tag, "_ackport"}, {30'b0, ack1, ack0},
            v.port ? 32'd2 : 32'd1);
        chk({tag, "_err"}, {31'b0, err}, {31'b0, v.err});
      end
    end
    chk({tag, "_lat"}, n, v.lat);
    req0 = 1'b0;
    req1 = 1'b0;
    tick;
    if (!v.rw && v.typ != 2'b11) begin
      if (v.port) rd1 = v.rdata;
      else        rd0 = v.rdata;
    end
    chk({tag, "_rdata0"}, rdata0, rd0);
    chk({tag, "_rdata1"}, rdata1, rd1);
    chk({tag, "_wecnt"}, wes,
        (v.rw && v.typ != 2'b11) ? v.lat - 1 : 0);
    if (v.typ != 2'b11) chk({tag, "_base"}, first, v.base);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [15:0] m0, m1, f0, f1;
    int acks;

    vt[0]  = '{1'b0, 1'b1, 2'b00, 32'h0A, 32'h11223344, 32'h0, 5, 1'b0, 8'h08};
    vt[1]  = '{1'b0, 1'b0, 2'b00, 32'h08, 32'h0, 32'h11223344, 5, 1'b0, 8'h08};
    vt[2]  = '{1'b1, 1'b1, 2'b01, 32'h0C, 32'h0000AABB, 32'h0, 3, 1'b0, 8'h0C};
    vt[3]  = '{1'b1, 1'b0, 2'b01, 32'h0D, 32'h0, 32'h0000AABB, 3, 1'b0, 8'h0C};
    vt[4]  = '{1'b1, 1'b0, 2'b10, 32'h0B, 32'h0, 32'h00000011, 2, 1'b0, 8'h0B};
    vt[5]  = '{1'b0, 1'b1, 2'b11, 32'h20, 32'hFFFFFFFF, 32'h0, 1, 1'b1, 8'h00};
    vt[6]  = '{1'b1, 1'b1, 2'b01, 32'h31, 32'hDEADBEEF, 32'h0, 3, 1'b0, 8'h30};
    vt[7]  = '{1'b0, 1'b0, 2'b01, 32'h30, 32'h0, 32'h0000BEEF, 3, 1'b0, 8'h30};
    vt[8]  = '{1'b1, 1'b1, 2'b10, 32'h43, 32'h000000A5, 32'h0, 2, 1'b0, 8'h43};
    vt[9]  = '{1'b0, 1'b0, 2'b00, 32'h40, 32'h0, 32'hA5000000, 5, 1'b0, 8'h40};
    vt[10] = '{1'b1, 1'b0, 2'b00, 32'h33, 32'h0, 32'h0000BEEF, 5, 1'b0, 8'h30};
    vt[11] = '{1'b1, 1'b0, 2'b11, 32'h00, 32'h0, 32'h0, 1, 1'b1, 8'h00};
    vt[12] = '{1'b0, 1'b1, 2'b00, 32'h10, 32'hC3C3C3C3, 32'h0, 5, 1'b0, 8'h10};

    tick;
    tick;
    chk("rst_ack", {30'b0, ack1, ack0}, 32'd0);
    chk("rst_err_busy_we", {29'b0, err, busy, m_we}, 32'd0);
    chk("rst_maddr", m_addr, 32'd0);
    chk("rst_mwdata", {24'b0, m_wdata}, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    rst = 1'b1;
    tick;

    for (int i = 0; i < 13; i++) access(i, vt[i]);

    chk("mem_word08", {mem[8'h0B], mem[8'h0A], mem[8'h09], mem[8'h08]},
        32'h11223344);
    chk("mem_half30", {16'b0, mem[8'h31], mem[8'h30]}, 32'h0000BEEF);
    chk("mem_20_untouched", {24'b0, mem[8'h20]}, 32'h0);

    // Reset in the cycle carrying the second byte of a word write.
    req0 = 1'b1; rw0 = 1'b1; type0 = 2'b00;
    addr0 = 32'h10; wdata0 = 32'h55667788;
    tick;
    chk("abort_b0", {23'b0, m_we, m_addr[7:0]}, 32'h110);
    tick;
    chk("abort_b1", {23'b0, m_we, m_addr[7:0]}, 32'h111);
    rst = 1'b0;
    tick;
    chk("abort_we", {29'b0, m_we, busy, ack0}, 32'd0);
    chk("abort_rdata0", rdata0, 32'd0);
    req0 = 1'b0;
    rst = 1'b1;
    rd0 = '0;
    rd1 = '0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (ack0 | ack1 | m_we) acks++;
    end
    chk("abort_no_ack", acks, 0);
    chk("abort_mem", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]},
        32'hC3C37788);
    access(20, '{1'b0, 1'b0, 2'b10, 32'h11, 32'h0, 32'h77, 2, 1'b0, 8'h11});

    // Both ports hold byte reads continuously after a fresh reset.
    rst = 1'b0;
    tick;
    rst = 1'b1;
    req0 = 1'b1; rw0 = 1'b0; type0 = 2'b10; addr0 = 32'h10;
    req1 = 1'b1; rw1 = 1'b0; type1 = 2'b10; addr1 = 32'h11;
    m0 = '0; m1 = '0; f0 = '0; f1 = '0;
    for (int n = 1; n <= 12; n++) begin
      tick;
      m0[n] = ack0;
      m1[n] = ack1;
      f0[n] = f_ack0;
      f1[n] = f_ack1;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick;
    tick;
    chk("rr_ack0_cycles", {16'b0, m0}, 32'h0104);
    chk("rr_ack1_cycles", {16'b0, m1}, 32'h0820);
    chk("fp_ack0_cycles", {16'b0, f0}, 32'h0924);
    chk("fp_ack1_cycles", {16'b0, f1}, 32'h0000);
    chk("rr_rdata0", rdata0, 32'h88);
    chk("rr_rdata1", rdata1, 32'h77);
    chk("fp_rdata0", f_rdata0, 32'h88);
    chk("fp_rdata1", f_rdata1, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
